// File: rtl/evg_sequence_trigger.sv
// Sequence trigger for the event generator: heartbeat timing, request merging and the
// delayed sequence-start state machine, with a saturating count of dropped requests.
module evg_sequence_trigger #(
  parameter int COUNTER_WIDTH = 32,
  parameter int DELAY_WIDTH   = 16
) (
  input  logic                     evgTxClk,
  input  logic                     evgReset,
  input  logic                     cfgEnable,
  input  logic [COUNTER_WIDTH-1:0] cfgHeartbeatInterval,
  input  logic [DELAY_WIDTH-1:0]   cfgSeqDivisor,
  input  logic [DELAY_WIDTH-1:0]   cfgSeqDelay,
  input  logic                     cfgExtEnable,
  input  logic                     extTrigger,
  input  logic                     cfgClearMissed,
  output logic                     evgHeartbeatRequest,
  output logic                     evgSequenceStart,
  output logic                     busy,
  output logic [DELAY_WIDTH-1:0]   missedCount
);

  typedef enum logic {IDLE = 1'b0, DELAY = 1'b1} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] hbCount;
  logic [COUNTER_WIDTH-1:0] hbEffective;
  logic                     hbArmed;
  logic                     hbRun;
  logic [DELAY_WIDTH-1:0]   divCount;
  logic [DELAY_WIDTH-1:0]   delayCount;
  logic                     extPrev;
  logic                     extPrimed;
  logic                     extRequest;
  logic                     returning;
  logic                     hbSeqRequest;
  logic                     request;
  logic                     blocked;
  logic                     accept;
  logic                     miss;

  function automatic logic [DELAY_WIDTH-1:0] satInc(input logic [DELAY_WIDTH-1:0] value);
    return (&value) ? value : value + DELAY_WIDTH'(1);
  endfunction

  always_comb begin
    hbRun        = cfgEnable && (cfgHeartbeatInterval != '0);
    // A disarmed counter stands for a fresh reload from the interval seen right now.
    hbEffective  = hbArmed ? hbCount : cfgHeartbeatInterval - COUNTER_WIDTH'(1);
    hbSeqRequest = evgHeartbeatRequest && (cfgSeqDivisor != '0) &&
                   (divCount == cfgSeqDivisor - DELAY_WIDTH'(1));
    request      = hbSeqRequest || extRequest;
    blocked      = (state == DELAY) || returning;
    accept       = request && !blocked;
    miss         = request && blocked;
  end

  // Heartbeat period control
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      hbArmed             <= 1'b0;
      evgHeartbeatRequest <= 1'b0;
    end else if (!hbRun) begin
      hbArmed             <= 1'b0;
      evgHeartbeatRequest <= 1'b0;
    end else if (hbEffective == '0) begin
      hbArmed             <= 1'b0;
      evgHeartbeatRequest <= 1'b1;
    end else begin
      hbArmed             <= 1'b1;
      evgHeartbeatRequest <= 1'b0;
    end
  end

  always_ff @(posedge evgTxClk) begin
    if (hbRun && (hbEffective != '0)) hbCount <= hbEffective - COUNTER_WIDTH'(1);
  end

  // Heartbeat divisor
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      divCount <= '0;
    end else if (cfgSeqDivisor == '0) begin
      divCount <= '0;
    end else if (evgHeartbeatRequest) begin
      divCount <= hbSeqRequest ? '0 : divCount + DELAY_WIDTH'(1);
    end
  end

  // External trigger edge detect; the first cycle after reset only primes the history.
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      extPrev    <= 1'b0;
      extPrimed  <= 1'b0;
      extRequest <= 1'b0;
    end else begin
      extPrev    <= extTrigger;
      extPrimed  <= 1'b1;
      extRequest <= cfgExtEnable && extPrimed && extTrigger && !extPrev;
    end
  end

  // Sequence start FSM
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      state            <= IDLE;
      evgSequenceStart <= 1'b0;
      returning        <= 1'b0;
    end else begin
      evgSequenceStart <= 1'b0;
      returning        <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (cfgSeqDelay == '0) evgSequenceStart <= 1'b1;
          else                   state            <= DELAY;
        end
      end else if (delayCount == '0) begin
        evgSequenceStart <= 1'b1;
        returning        <= 1'b1;
        state            <= IDLE;
      end
    end
  end

  always_ff @(posedge evgTxClk) begin
    if (state == IDLE) begin
      if (accept) delayCount <= cfgSeqDelay - DELAY_WIDTH'(1);
    end else if (delayCount != '0) begin
      delayCount <= delayCount - DELAY_WIDTH'(1);
    end
  end

  assign busy = (state == DELAY);

  // Dropped-request counter
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      missedCount <= '0;
    end else if (cfgClearMissed) begin
      missedCount <= miss ? DELAY_WIDTH'(1) : '0;
    end else if (miss) begin
      missedCount <= satInc(missedCount);
    end
  end

endmodule

// File: tb/tb_evg_sequence_trigger.sv
// Bench for evg_sequence_trigger: directed scenarios plus randomized traffic, all checked
// against a cycle-numbered reference model of heartbeats, requests and sequence starts.
module tb_evg_sequence_trigger;
  localparam int CW   = 16;
  localparam int DW   = 8;
  localparam int MAXM = (1 << DW) - 1;

  logic          clk         = 1'b0;
  logic          rst         = 1'b0;
  logic          cfgEnable   = 1'b0;
  logic [CW-1:0] cfgInterval = '0;
  logic [DW-1:0] cfgDiv      = '0;
  logic [DW-1:0] cfgDelay    = '0;
  logic          cfgExtEn    = 1'b0;
  logic          extTrig     = 1'b0;
  logic          cfgClear    = 1'b0;
  logic          hbOut;
  logic          startOut;
  logic          busyOut;
  logic [DW-1:0] missedOut;

  int checks = 0;
  int fails  = 0;

  int cyc, pulses, hbDue, blockedUntil, startAt, busyFrom, busyTo, expMissed, busyCnt;
  bit hbRun, expHb, expExtReq, extPrevM, primed, expStart, expBusy;
  int hbLog[$];
  int startLog[$];

  always #5 clk = ~clk;

  evg_sequence_trigger #(.COUNTER_WIDTH(CW), .DELAY_WIDTH(DW)) dut (
    .evgTxClk            (clk),
    .evgReset            (rst),
    .cfgEnable           (cfgEnable),
    .cfgHeartbeatInterval(cfgInterval),
    .cfgSeqDivisor       (cfgDiv),
    .cfgSeqDelay         (cfgDelay),
    .cfgExtEnable        (cfgExtEn),
    .extTrigger          (extTrig),
    .cfgClearMissed      (cfgClear),
    .evgHeartbeatRequest (hbOut),
    .evgSequenceStart    (startOut),
    .busy                (busyOut),
    .missedCount         (missedOut)
  );

  task automatic model_reset();
    cyc = 0; pulses = 0; hbDue = 0; blockedUntil = 0; startAt = -1;
    busyFrom = 1; busyTo = 0; expMissed = 0; busyCnt = 0;
    hbRun = 0; expHb = 0; expExtReq = 0; extPrevM = 0; primed = 0;
    expStart = 0; expBusy = 0;
    hbLog.delete();
    startLog.delete();
  endtask

  // Caller raises rst first; this holds it for some edges and releases it between edges.
  task automatic apply_reset(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Advance one cycle; the model sees the same inputs the DUT sampled at the edge.
  task automatic tick();
    int  r, d, dv;
    bit  hbReq, req, missNow;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    r  = cyc - 1;
    d  = int'(cfgDelay);
    dv = int'(cfgDiv);
    hbReq = 0;
    if (expHb && dv != 0) begin
      hbReq = ((pulses % dv) == dv - 1);
      pulses++;
    end
    req = hbReq || expExtReq;
    missNow = 0;
    if (req) begin
      if (r <= blockedUntil) missNow = 1;
      else if (d == 0) startAt = r + 1;
      else begin
        startAt = r + d + 1;
        busyFrom = r + 1;
        busyTo = r + d;
        blockedUntil = r + d + 1;
      end
    end
    if (cfgClear) expMissed = missNow ? 1 : 0;
    else if (missNow && expMissed < MAXM) expMissed++;
    expStart = (cyc == startAt);
    expBusy  = (cyc >= busyFrom) && (cyc <= busyTo);
    if (!cfgEnable || cfgInterval == 0) begin
      hbRun = 0;
      expHb = 0;
    end else begin
      if (!hbRun) begin
        hbRun = 1;
        hbDue = cyc + int'(cfgInterval) - 1;
      end
      expHb = (cyc == hbDue);
      if (expHb) hbRun = 0;
    end
    expExtReq = primed && cfgExtEn && extTrig && !extPrevM;
    extPrevM  = extTrig;
    primed    = 1;
    if (hbOut) hbLog.push_back(cyc);
    if (startOut) startLog.push_back(cyc);
    if (busyOut) busyCnt++;
  endtask

  task automatic test_reset();
    cfgEnable = 0; cfgInterval = '0; cfgDiv = 8'd1; cfgDelay = '0;
    cfgExtEn = 1; extTrig = 1; cfgClear = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hbOut, startOut, busyOut, missedOut} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got hb=%b start=%b busy=%b missed=%0d, expected all zero",
               hbOut, startOut, busyOut, missedOut);
    end
    apply_reset(3);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL reset_ext cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
      if (i == 5) begin
        checks++;
        if (startLog.size() != 0) begin
          fails++;
          $display("FAIL ext_high_at_release: got %0d starts, expected 0", startLog.size());
        end
        extTrig = 0;
      end
      if (i == 6) extTrig = 1;
    end
    checks++;
    if (startLog.size() != 1 || startLog[0] != 8) begin
      fails++;
      $display("FAIL ext_after_release: got %0d starts (first at %0d), expected one at 8",
               startLog.size(), startLog.size() > 0 ? startLog[0] : -1);
    end
  endtask

  task automatic test_periodic();
    cfgEnable = 1; cfgInterval = 16'd10; cfgDiv = 8'd1; cfgDelay = '0;
    cfgExtEn = 0; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 0; i < 31; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL periodic cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    checks++;
    if (hbLog.size() != 3 || hbLog[0] != 10 || hbLog[1] != 20 || hbLog[2] != 30) begin
      fails++;
      $display("FAIL periodic_hb_cycles: got %0d pulses, expected cycles 10,20,30", hbLog.size());
    end
    checks++;
    if (startLog.size() != 3 || startLog[0] != 11 || startLog[1] != 21 || startLog[2] != 31) begin
      fails++;
      $display("FAIL periodic_start_cycles: got %0d starts, expected cycles 11,21,31", startLog.size());
    end
  endtask

  task automatic test_divisor_delay();
    cfgEnable = 1; cfgInterval = 16'd4; cfgDiv = 8'd3; cfgDelay = 8'd5;
    cfgExtEn = 0; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL divisor_delay cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    checks++;
    if (startLog.size() != 2 || startLog[0] != 18 || startLog[1] != 30) begin
      fails++;
      $display("FAIL divisor_start_cycles: got %0d starts, expected cycles 18,30", startLog.size());
    end
    checks++;
    if (busyCnt != 10 || hbLog.size() != 7) begin
      fails++;
      $display("FAIL divisor_busy_hb: got busy=%0d hb=%0d, expected busy=10 hb=7", busyCnt, hbLog.size());
    end
  endtask

  task automatic test_missed();
    cfgEnable = 1; cfgInterval = 16'd4; cfgDiv = 8'd1; cfgDelay = 8'd6;
    cfgExtEn = 0; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL missed cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    checks++;
    if (missedOut !== 8'd1 || startLog.size() != 1 || startLog[0] != 11) begin
      fails++;
      $display("FAIL missed_summary: got missed=%0d starts=%0d, expected missed=1 one start at 11",
               missedOut, startLog.size());
    end
  endtask

  task automatic test_external();
    cfgEnable = 1; cfgInterval = '0; cfgDiv = 8'd1; cfgDelay = 8'd2;
    cfgExtEn = 1; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 1; i <= 26; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL external cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
      if (i == 20) extTrig = 1;
    end
    checks++;
    if (startLog.size() != 1 || startLog[0] != 24 || hbLog.size() != 0) begin
      fails++;
      $display("FAIL external_summary: got starts=%0d hb=%0d, expected one start at 24 and no heartbeats",
               startLog.size(), hbLog.size());
    end
  endtask

  task automatic test_reset_mid_delay();
    cfgEnable = 1; cfgInterval = 16'd5; cfgDiv = 8'd1; cfgDelay = 8'd3;
    cfgExtEn = 0; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL pre_reset cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hbOut, startOut, busyOut, missedOut} !== '0) begin
      fails++;
      $display("FAIL mid_delay_reset: got hb=%b start=%b busy=%b missed=%0d, expected all zero",
               hbOut, startOut, busyOut, missedOut);
    end
    apply_reset(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL post_reset cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    checks++;
    if (hbLog.size() != 2 || hbLog[0] != 5 || hbLog[1] != 10 || startLog.size() != 1 || startLog[0] != 9) begin
      fails++;
      $display("FAIL post_reset_summary: got hb=%0d starts=%0d, expected hb at 5,10 and one start at 9",
               hbLog.size(), startLog.size());
    end
  endtask

  task automatic test_saturation();
    cfgEnable = 1; cfgInterval = 16'd1; cfgDiv = 8'd1; cfgDelay = 8'd255;
    cfgExtEn = 0; extTrig = 0; cfgClear = 0;
    rst = 1'b1;
    apply_reset(2);
    for (int i = 0; i < 270; i++) begin
      tick();
      checks++;
      if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
        fails++;
        $display("FAIL saturation cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                 cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
      end
    end
    checks++;
    if (missedOut !== 8'hFF) begin
      fails++;
      $display("FAIL missed_saturated: got %0d, expected 255", missedOut);
    end
    cfgClear = 1;
    tick();
    cfgClear = 0;
    checks++;
    if (missedOut !== 8'd1 || expMissed != 1) begin
      fails++;
      $display("FAIL clear_with_miss: got %0d, expected 1", missedOut);
    end
    tick();
    checks++;
    if (missedOut !== 8'd2) begin
      fails++;
      $display("FAIL miss_after_clear: got %0d, expected 2", missedOut);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 6; round++) begin
      cfgEnable = 1;
      cfgInterval = CW'($urandom_range(0, 6));
      cfgDiv = DW'($urandom_range(0, 3));
      cfgDelay = DW'($urandom_range(0, 5));
      cfgExtEn = ($urandom_range(0, 1) == 1);
      extTrig = 0; cfgClear = 0;
      rst = 1'b1;
      apply_reset(1);
      for (int i = 0; i < 300; i++) begin
        tick();
        checks++;
        if ({hbOut, startOut, busyOut, missedOut} !== {expHb, expStart, expBusy, DW'(expMissed)}) begin
          fails++;
          $display("FAIL random round %0d cycle %0d: got hb=%b start=%b busy=%b missed=%0d, expected hb=%b start=%b busy=%b missed=%0d",
                   round, cyc, hbOut, startOut, busyOut, missedOut, expHb, expStart, expBusy, expMissed);
        end
        if ($urandom_range(0, 9) < 3) extTrig = ~extTrig;
        cfgClear = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 39) == 0) cfgEnable = ~cfgEnable;
        if ($urandom_range(0, 49) == 0) cfgInterval = CW'($urandom_range(0, 6));
        if ($urandom_range(0, 9) == 0) cfgDelay = DW'($urandom_range(0, 5));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_divisor_delay();
    test_missed();
    test_external();
    test_reset_mid_delay();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/evg_sequence_trigger.md
EVG_SEQUENCE_TRIGGER -- requirements
Module: evgSequenceTrigger

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of the heartbeat interval counter.
REQ-002 SHALL have parameter DELAY_WIDTH, default 16, width of the divisor, delay and miss counters.
REQ-003 evgTxClk  input  1  sole clock; all logic rising-edge.
REQ-004 evgReset  input  1  asynchronous, active-high reset.
REQ-005 cfgEnable  input  1  heartbeat generator enable (quasi-static).
REQ-006 cfgHeartbeatInterval  input  COUNTER_WIDTH  heartbeat period in evgTxClk cycles; 0 disables heartbeats.
REQ-007 cfgSeqDivisor  input  DELAY_WIDTH  sequence request every N heartbeats; 0 disables heartbeat-derived requests.
REQ-008 cfgSeqDelay  input  DELAY_WIDTH  cycles from request to sequence start.
REQ-009 cfgExtEnable  input  1  enables external trigger requests.
REQ-010 extTrigger  input  1  synchronous level; rising edge is a request.
REQ-011 cfgClearMissed  input  1  one-cycle pulse; clears missedCount.
REQ-012 evgHeartbeatRequest  output  1  registered one-cycle heartbeat pulse to evgSource.
REQ-013 evgSequenceStart  output  1  registered one-cycle pulse to evgSource.
REQ-014 busy  output  1  high while FSM in DELAY.
REQ-015 missedCount  output  DELAY_WIDTH  saturating count of dropped requests.

Function
REQ-016 Heartbeat counter SHALL count down from cfgHeartbeatInterval-1; at 0 it SHALL assert evgHeartbeatRequest next cycle and reload.
REQ-017 Counting from the first edge after reset release as cycle 1, with cfgEnable high and interval N>0, evgHeartbeatRequest SHALL be high in cycles N, 2N, 3N, ...
REQ-018 Interval 1 SHALL yield evgHeartbeatRequest high every cycle; interval 0 or cfgEnable low SHALL hold the counter at reload and emit no pulses.
REQ-019 Interval changes SHALL take effect only at the next reload; re-enable SHALL restart a full period.
REQ-020 Divisor counter SHALL increment on each heartbeat pulse; on the pulse where it equals cfgSeqDivisor-1 it SHALL wrap to 0 and raise a heartbeat request in that same cycle.
REQ-021 cfgSeqDivisor 0 SHALL hold the divisor counter at 0 and raise no heartbeat requests.
REQ-022 With cfgExtEnable high, an extTrigger rising edge (one-register edge detect) SHALL raise an external request in the cycle after the edge.
REQ-023 Simultaneous heartbeat and external requests SHALL merge into one request, no miss counted.
REQ-024 FSM states IDLE, DELAY; IDLE+request and cfgSeqDelay 0 -> evgSequenceStart high next cycle, stay IDLE.
REQ-025 IDLE+request and cfgSeqDelay D>0 -> load D-1, go DELAY; DELAY decrements; at 0 -> evgSequenceStart high next cycle, go IDLE.
REQ-026 Sequence start SHALL occur exactly D+1 cycles after the request cycle for all D; cfgSeqDelay SHALL be sampled only at request acceptance.
REQ-027 A request arriving in DELAY, or in the cycle DELAY returns to IDLE, SHALL be dropped and increment missedCount.
REQ-028 missedCount SHALL saturate at all-ones; increment and cfgClearMissed in the same cycle SHALL yield 1.
REQ-029 busy SHALL equal (state == DELAY).

Reset
REQ-030 evgReset SHALL asynchronously force evgHeartbeatRequest=0, evgSequenceStart=0, busy=0, missedCount=0, FSM=IDLE, divisor counter=0, edge-detect register=0, heartbeat counter to reload state.
REQ-031 Reset asserted mid-DELAY SHALL abort the pending start; no evgSequenceStart SHALL follow reset release until a new request.
REQ-032 extTrigger high at reset release SHALL NOT count as a rising edge.

Verification
REQ-033 Interval 10, divisor 1, delay 0, enable from reset -> heartbeat at cycles 10,20,30; sequence start at 11,21,31.
REQ-034 Interval 4, divisor 3, delay 5 -> heartbeats 4,8,12,...; requests at 12,24; starts at 18,30; busy high cycles 13-17.
REQ-035 Interval 4, divisor 1, delay 6 -> request at 4 accepted, request at 8 dropped, missedCount=1; start at 11 only until request at 12.
REQ-036 Interval 0, ext enabled, extTrigger rises at cycle 20, delay 2 -> request 21, start 24; no heartbeats ever.
REQ-037 Interval 5, delay 3, reset asserted cycle 7 (in DELAY) for 2 cycles -> all outputs 0 immediately, no start at 9, heartbeat period restarts from release.
REQ-038 missedCount preloaded to all-ones by forced misses, further miss -> stays all-ones; clear coincident with miss -> 1.
